// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: two-road traffic-light phase sequencer timed by a 25 ms tick
// Ports: clk, rst_n (async, active-low); tick in / en_tick out (tick generator handshake);
//   run (1 = cycle phases, 0 = all-red idle); ped_req (one-cycle pedestrian pulse);
//   ns_led / ew_led {red,yellow,green}; phase (state code); sec_left (seconds left in phase).
// Option: define TRAFFIC_YELLOW_BLINK_EN to blink the active yellow at half-second rate.
module traffic_phase_ctrl #(
  parameter int G_SEC         = 30,
  parameter int Y_SEC         = 3,
  parameter int R_SEC         = 1,
  parameter int MIN_G_SEC     = 10,
  parameter int TICKS_PER_SEC = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  output logic       en_tick,
  input  logic       run,
  input  logic       ped_req,
  output logic [2:0] ns_led,
  output logic [2:0] ew_led,
  output logic [2:0] phase,
  output logic [6:0] sec_left
);
  localparam int SW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'(TICKS_PER_SEC - 1);
  localparam logic [6:0] G7 = 7'(G_SEC);
  localparam logic [6:0] Y7 = 7'(Y_SEC);
  localparam logic [6:0] R7 = 7'(R_SEC);
`ifdef TRAFFIC_YELLOW_BLINK_EN
  localparam logic [SW-1:0] HALF = SW'(TICKS_PER_SEC / 2);
`endif
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    RED_A = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    RED_B = 3'd6
  } state_e;
  logic [2:0]    state_q, state_d;
  logic [SW-1:0] subcnt_q, subcnt_d;
  logic [6:0]    sec_left_q, sec_left_d;
  logic          ped_pend_q, ped_pend_d;
  logic          en_tick_q, en_tick_d;
  logic [2:0]    ns_led_q, ns_led_d;
  logic [2:0]    ew_led_q, ew_led_d;
  logic          wrap, green, min_met, adv, ybit;
  logic [2:0]    nxt;
  logic [6:0]    nxt_dur;
  always_comb begin
    wrap    = tick && subcnt_q == SUB_MAX;
    green   = state_q == NS_G || state_q == EW_G;
    // elapsed = G_SEC - sec_left + 1 >= MIN_G_SEC, rearranged to stay unsigned
    min_met = {1'b0, sec_left_q} + 8'(MIN_G_SEC) <= 8'(G_SEC + 1);
    adv     = wrap && (sec_left_q == 7'd1 || (green && ped_pend_q && min_met));
    nxt     = state_q == RED_B ? NS_G : state_q + 3'd1;
    nxt_dur = (nxt == NS_G || nxt == EW_G) ? G7 : (nxt == NS_Y || nxt == EW_Y) ? Y7 : R7;
    state_d    = state_q;
    subcnt_d   = subcnt_q;
    sec_left_d = sec_left_q;
    ped_pend_d = ped_pend_q | ped_req;
    // run low wins over everything; IDLE and the unused code 7 land here too
    if (!run || state_q == IDLE || state_q == 3'd7) begin
      state_d    = run && state_q == IDLE ? NS_G : IDLE;
      subcnt_d   = '0;
      sec_left_d = state_d == NS_G ? G7 : 7'd0;
      ped_pend_d = 1'b0;
    end else if (tick) begin
      subcnt_d = wrap ? '0 : subcnt_q + SW'(1);
      if (adv) begin
        state_d    = nxt;
        sec_left_d = nxt_dur;
        ped_pend_d = green ? 1'b0 : ped_pend_q | ped_req;
      end else if (wrap) begin
        sec_left_d = sec_left_q - 7'd1;
      end
    end
    en_tick_d = state_d != IDLE;
`ifdef TRAFFIC_YELLOW_BLINK_EN
    ybit = subcnt_d < HALF;
`else
    ybit = 1'b1;
`endif
    ns_led_d = state_d == NS_G ? 3'b001 : state_d == NS_Y ? {1'b0, ybit, 1'b0} : 3'b100;
    ew_led_d = state_d == EW_G ? 3'b001 : state_d == EW_Y ? {1'b0, ybit, 1'b0} : 3'b100;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      subcnt_q   <= '0;
      sec_left_q <= '0;
      ped_pend_q <= 1'b0;
      en_tick_q  <= 1'b0;
      ns_led_q   <= 3'b100;
      ew_led_q   <= 3'b100;
    end else begin
      state_q    <= state_d;
      subcnt_q   <= subcnt_d;
      sec_left_q <= sec_left_d;
      ped_pend_q <= ped_pend_d;
      en_tick_q  <= en_tick_d;
      ns_led_q   <= ns_led_d;
      ew_led_q   <= ew_led_d;
    end
  end
  assign en_tick  = en_tick_q;
  assign ns_led   = ns_led_q;
  assign ew_led   = ew_led_q;
  assign phase    = state_q;
  assign sec_left = sec_left_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: vector table, corner sequences and random run against a tick-count model
module tb_traffic_phase_ctrl;
  localparam int G = 3, Y = 1, R = 1, MN = 1, TPS = 4;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, run = 1'b0, ped_req = 1'b0;
  logic en_tick;
  logic [2:0] ns_led, ew_led, phase;
  logic [6:0] sec_left;
  int n_chk = 0, n_fail = 0;
  int m_ph = 0, m_e = 0;
  bit m_pend = 0;
  traffic_phase_ctrl #(.G_SEC(G), .Y_SEC(Y), .R_SEC(R), .MIN_G_SEC(MN), .TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .en_tick(en_tick), .run(run), .ped_req(ped_req),
    .ns_led(ns_led), .ew_led(ew_led), .phase(phase), .sec_left(sec_left)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, p, t;
    int ph;
    logic [2:0] ns, ew;
    int sec;
    logic en;
  } vec_t;
  vec_t tbl[15];
  int exp_seq[6] = '{2, 3, 4, 5, 6, 1};
  int exp_cnt[6] = '{12, 4, 4, 12, 4, 4};
  task automatic chk(input string n, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  function automatic int dur(input int p);
    return (p == 1 || p == 4) ? G : (p == 2 || p == 5) ? Y : R;
  endfunction
  function automatic logic [2:0] led(input int ph, input int e, input bit ns);
    int g = ns ? 1 : 4;
    int yl = ns ? 2 : 5;
    logic yb = 1'b1;
`ifdef TRAFFIC_YELLOW_BLINK_EN
    yb = (e % TPS) < TPS / 2;
`endif
    return ph == g ? 3'b001 : ph == yl ? {1'b0, yb, 1'b0} : 3'b100;
  endfunction
  // model: phase index plus ticks elapsed since phase entry
  task automatic model(input logic r, input logic p, input logic t);
    bit old_pend, gr, done, early;
    if (!r) begin
      m_ph = 0; m_e = 0; m_pend = 0;
    end else if (m_ph == 0) begin
      m_ph = 1; m_e = 0; m_pend = 0;
    end else begin
      old_pend = m_pend;
      m_pend = m_pend | p;
      if (t) begin
        m_e++;
        gr = m_ph == 1 || m_ph == 4;
        done = m_e == dur(m_ph) * TPS;
        early = gr && old_pend && m_e % TPS == 0 && m_e / TPS >= MN;
        if (done || early) begin
          if (gr) m_pend = 0;
          m_ph = m_ph == 6 ? 1 : m_ph + 1;
          m_e = 0;
        end
      end
    end
  endtask
  task automatic check_model();
    chk("phase", int'(phase), m_ph);
    chk("ns_led", int'(ns_led), int'(led(m_ph, m_e, 1'b1)));
    chk("ew_led", int'(ew_led), int'(led(m_ph, m_e, 1'b0)));
    chk("sec_left", int'(sec_left), m_ph == 0 ? 0 : dur(m_ph) - m_e / TPS);
    chk("en_tick", int'(en_tick), m_ph != 0 ? 1 : 0);
    chk("ped_pend", int'(dut.ped_pend_q), int'(m_pend));
  endtask
  task automatic step(input logic r, input logic p, input logic t);
    run = r; ped_req = p; tick = t;
    @(posedge clk);
    model(r, p, t);
    #1;
    check_model();
  endtask
  task automatic chk_idle(input string n);
    chk({n, "_phase"}, int'(phase), 0);
    chk({n, "_ns"}, int'(ns_led), 3'b100);
    chk({n, "_ew"}, int'(ew_led), 3'b100);
    chk({n, "_en"}, int'(en_tick), 0);
    chk({n, "_sec"}, int'(sec_left), 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; ped_req = 1'b0; tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    rst_n = 1'b1;
    m_ph = 0; m_e = 0; m_pend = 0;
  endtask
  task automatic run_until(input int ph, input string n);
    int i;
    for (i = 0; i < 400 && phase != 3'(ph); i++) step(1'b1, 1'b0, i % 5 == 0);
    chk(n, int'(phase), ph);
  endtask
  initial begin
    int prev, cnt, k;
    tbl[0]  = '{1, 0, 0, 1, 3'b001, 3'b100, 3, 1};
    tbl[1]  = '{1, 0, 1, 1, 3'b001, 3'b100, 3, 1};
    tbl[2]  = '{1, 0, 1, 1, 3'b001, 3'b100, 3, 1};
    tbl[3]  = '{1, 0, 1, 1, 3'b001, 3'b100, 3, 1};
    tbl[4]  = '{1, 0, 1, 1, 3'b001, 3'b100, 2, 1};
    tbl[5]  = '{1, 0, 0, 1, 3'b001, 3'b100, 2, 1};
    tbl[6]  = '{0, 0, 0, 0, 3'b100, 3'b100, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 3'b100, 3'b100, 0, 0};
    tbl[8]  = '{1, 0, 0, 1, 3'b001, 3'b100, 3, 1};
    tbl[9]  = '{1, 0, 1, 1, 3'b001, 3'b100, 3, 1};
    tbl[10] = '{1, 1, 1, 1, 3'b001, 3'b100, 3, 1};
    tbl[11] = '{1, 0, 1, 1, 3'b001, 3'b100, 3, 1};
    tbl[12] = '{1, 0, 1, 2, 3'b010, 3'b100, 1, 1};
    tbl[13] = '{1, 0, 0, 2, 3'b010, 3'b100, 1, 1};
    tbl[14] = '{1, 0, 1, 2, 3'b010, 3'b100, 1, 1};
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].p, tbl[i].t);
      chk("tbl_phase", int'(phase), tbl[i].ph);
      chk("tbl_ns", int'(ns_led), int'(tbl[i].ns));
      chk("tbl_ew", int'(ew_led), int'(tbl[i].ew));
      chk("tbl_sec", int'(sec_left), tbl[i].sec);
      chk("tbl_en", int'(en_tick), int'(tbl[i].en));
    end
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    prev = 1; cnt = 0; k = 0;
    for (int i = 0; i < 220 && k < 6; i++) begin
      step(1'b1, 1'b0, i % 5 == 0);
      if (i % 5 == 0) cnt++;
      if (int'(phase) != prev) begin
        chk("free_phase", int'(phase), exp_seq[k]);
        chk("free_ticks", cnt, exp_cnt[k]);
        k++; cnt = 0; prev = int'(phase);
      end
    end
    chk("free_done", k, 6);
    run_until(5, "reach_ew_y");
    step(1'b0, 1'b0, 1'b0);
    chk_idle("run_off");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, i % 2 == 0);
    chk_idle("idle_ticks");
    step(1'b1, 1'b0, 1'b0);
    force dut.state_q = 3'd7;
    #1;
    chk("forced", int'(phase), 7);
    release dut.state_q;
    @(posedge clk);
    #1;
    chk_idle("illegal");
    m_ph = 0; m_e = 0; m_pend = 0;
    check_model();
    step(1'b1, 1'b0, 1'b0);
    run_until(6, "reach_red_b");
    step(1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ph = 0; m_e = 0; m_pend = 0;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
